// File: rtl/mem_arbiter_rr.sv
// N-port block-request arbiter in front of one main-memory channel.
// Read responses come back in issue order and are routed by a FIFO of port IDs.
module mem_arbiter_rr #(
   parameter int unsigned NUM_PORTS       = 2,
   parameter int unsigned ADDR_W          = 26,
   parameter int unsigned DATA_W          = 512,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned PRIO_MODE       = 0
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NUM_PORTS-1:0]                req_valid_i,
   input  logic [NUM_PORTS-1:0]                req_type_i,
   input  logic [NUM_PORTS*ADDR_W-1:0]         req_block_addr_i,
   input  logic [NUM_PORTS*DATA_W-1:0]         req_block_data_i,
   output logic [NUM_PORTS-1:0]                req_ready_o,
   output logic                                mem_req_valid_o,
   input  logic                                mem_req_ready_i,
   output logic                                mem_req_type_o,
   output logic [ADDR_W-1:0]                   mem_req_block_addr_o,
   output logic [DATA_W-1:0]                   mem_req_block_data_o,
   input  logic                                mem_resp_valid_i,
   input  logic [DATA_W-1:0]                   mem_resp_block_data_i,
   output logic [NUM_PORTS-1:0]                resp_valid_o,
   output logic [DATA_W-1:0]                   resp_block_data_o,
   output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_cnt_o,
   output logic                                resp_err_o
);

   localparam int unsigned PID_W = $clog2(NUM_PORTS);
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

   logic [PID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              mem_req_valid_q, mem_req_valid_d;
   logic              mem_req_type_q, mem_req_type_d;
   logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
   logic [DATA_W-1:0] mem_req_data_q, mem_req_data_d;
   logic [PID_W-1:0]  fifo_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic                 slot_free, can_read, pop, push, found, grant, sel_type;
   logic [NUM_PORTS-1:0] eligible;
   logic [PID_W-1:0]     grant_idx;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_data;
   int unsigned          idx;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign pop       = mem_resp_valid_i && (cnt_q != '0);
   assign slot_free = !mem_req_valid_q || mem_req_ready_i;
   // A read popped this cycle frees a slot for a read granted this cycle.
   assign can_read  = (cnt_q < MaxCnt) || pop;
   assign eligible  = req_valid_i & (req_type_i | {NUM_PORTS{can_read}});

   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (PRIO_MODE == 1) idx = i;
         else                idx = (32'(rr_ptr_q) + i) % NUM_PORTS;
         if (!found && eligible[idx[PID_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = idx[PID_W-1:0];
         end
      end
      grant       = found && slot_free;
      req_ready_o = grant ? (NUM_PORTS'(1) << grant_idx) : '0;
   end

   always_comb begin
      sel_type = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (req_ready_o[i]) begin
            sel_type = req_type_i[i];
            sel_addr = req_block_addr_i[i*ADDR_W +: ADDR_W];
            sel_data = req_block_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign push = grant && !sel_type;

   always_comb begin
      rr_ptr_d        = rr_ptr_q;
      mem_req_valid_d = mem_req_valid_q;
      mem_req_type_d  = mem_req_type_q;
      mem_req_addr_d  = mem_req_addr_q;
      mem_req_data_d  = mem_req_data_q;
      wr_ptr_d        = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d        = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cnt_d           = cnt_q;
      err_d           = err_q | (mem_resp_valid_i && (cnt_q == '0));
      if (mem_req_valid_q && mem_req_ready_i) mem_req_valid_d = 1'b0;
      if (grant) begin
         mem_req_valid_d = 1'b1;
         mem_req_type_d  = sel_type;
         mem_req_addr_d  = sel_addr;
         mem_req_data_d  = sel_type ? sel_data : '0;
         if (PRIO_MODE == 0) begin
            rr_ptr_d = (grant_idx == PID_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
         end
      end
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q        <= '0;
         mem_req_valid_q <= 1'b0;
         mem_req_type_q  <= 1'b0;
         mem_req_addr_q  <= '0;
         mem_req_data_q  <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         cnt_q           <= '0;
         err_q           <= 1'b0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      end else begin
         rr_ptr_q        <= rr_ptr_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_req_type_q  <= mem_req_type_d;
         mem_req_addr_q  <= mem_req_addr_d;
         mem_req_data_q  <= mem_req_data_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         cnt_q           <= cnt_d;
         err_q           <= err_d;
         if (push) fifo_q[wr_ptr_q] <= grant_idx;
      end
   end

   assign mem_req_valid_o      = mem_req_valid_q;
   assign mem_req_type_o       = mem_req_type_q;
   assign mem_req_block_addr_o = mem_req_addr_q;
   assign mem_req_block_data_o = mem_req_data_q;
   assign resp_valid_o         = pop ? (NUM_PORTS'(1) << fifo_q[rd_ptr_q]) : '0;
   assign resp_block_data_o    = pop ? mem_resp_block_data_i : '0;
   assign outstanding_cnt_o    = cnt_q;
   assign resp_err_o           = err_q;

endmodule
